// File: rtl/sms23_52_inv_sbox_seq_if.sv
// Operand/result handshake bundle for the sequential inverse S-box.
// Latency: none, wires only.
// Backpressure: valid/ready on both the operand side and the result side.
interface sms23_52_inv_sbox_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sms23_52_inv_sbox_seq.sv
// Inverse of the power-40 S-box: y = x^EXP in GF(2^6), p(t) = t^6+t+1, one exponent bit per clock.
// Latency: out_valid is first seen in the 6th cycle after the accept cycle; accepts spaced >= 7 clocks.
// Backpressure: result is held stable in DONE until out_ready; no new operand is taken until IDLE.
module sms23_52_inv_sbox_seq #(
  parameter int EXP      = 52,
  parameter int EXP_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sms23_52_inv_sbox_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] EXP_V     = EXP[5:0];
  localparam logic [2:0] CNT_START = 3'(EXP_BITS - 2);

  // Carry-less 6x6 product folded back with t^6 = t + 1.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ ({5'b0, a} << i);
    end
    for (int i = 10; i >= 6; i--) begin
      if (p[i]) p = p ^ (11'b000_0100_0011 << (i - 6));
    end
    return p[5:0];
  endfunction

  logic [1:0] state;
  logic [5:0] acc;
  logic [5:0] op;
  logic [2:0] cnt;
  logic [5:0] sq_acc;
  logic [5:0] mul_acc;
  logic [5:0] acc_next;

  // One squarer and one multiplier; the exponent bit picks whether the multiply is kept.
  always_comb begin
    sq_acc   = gf_mul(acc, acc);
    mul_acc  = gf_mul(sq_acc, op);
    acc_next = EXP_V[cnt] ? mul_acc : sq_acc;
  end

  // Handshake outputs decode directly from the state; result only shown in DONE.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_data  = (state == DONE) ? acc : 6'd0;
    bus.busy      = (state != IDLE);
  end

  // Control FSM and datapath registers; the top exponent bit is consumed at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      op    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op    <= bus.in_data;
            acc   <= bus.in_data;
            cnt   <= CNT_START;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
